// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding and
// default geometry of the instruction store.
package imem_pkg;

    localparam int unsigned DEPTH_DEF  = 36;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/imem_fetch_sequencer_store.sv
// Byte-wide instruction store: synchronous write port, asynchronous read port.
// Addresses at or beyond DEPTH are ignored on write and read back as zero.
module imem_store
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [DATA_W-1:0] RdData
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge Clk) begin
        if (WrEn && (WrAddr < DEPTH_A)) begin
            mem_q[WrAddr[IDX_W-1:0]] <= WrData;
        end
    end

    assign RdData = (RdAddr < DEPTH_A) ? mem_q[RdAddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Loads a program byte stream into the instruction store, then fetches it in PC
// order into a one-entry valid/ready output register, with jumps and fault detection.
module imem_fetch_sequencer
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LoadValid,
    input  logic [DATA_W-1:0] LoadData,
    input  logic              LoadLast,
    output logic              LoadReady,
    input  logic              InstrReady,
    output logic              InstrValid,
    output logic [DATA_W-1:0] InstrCode,
    output logic [ADDR_W-1:0] InstrPC,
    input  logic              JumpEn,
    input  logic [ADDR_W-1:0] JumpTarget,
    output logic              Halted,
    output logic              Fault
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic [ADDR_W-1:0] prog_len_q, prog_len_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0] instr_code_q, instr_code_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] rd_data;

    logic load_fire;
    logic load_done;
    logic jump_bad;
    logic out_free;

    assign load_fire = (state_q == ST_LOAD) && LoadValid;
    // The store filling up ends the load just like an explicit LoadLast.
    assign load_done = load_fire && (LoadLast || (load_ptr_q == LAST_ADDR));
    assign jump_bad  = JumpEn && (JumpTarget >= prog_len_q);
    assign out_free  = !valid_q || InstrReady;

    imem_store #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store (
        .Clk    (Clk),
        .WrEn   (load_fire),
        .WrAddr (load_ptr_q),
        .WrData (LoadData),
        .RdAddr (pc_q),
        .RdData (rd_data)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_LOAD;
            load_ptr_q   <= '0;
            prog_len_q   <= '0;
            pc_q         <= '0;
            instr_pc_q   <= '0;
            instr_code_q <= '0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            prog_len_q   <= prog_len_d;
            pc_q         <= pc_d;
            instr_pc_q   <= instr_pc_d;
            instr_code_q <= instr_code_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (jump_bad) begin
                    state_d = ST_HALT;
                end else if (!JumpEn && out_free && (pc_q >= prog_len_q)) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        load_ptr_d   = load_ptr_q;
        prog_len_d   = prog_len_q;
        pc_d         = pc_q;
        instr_pc_d   = instr_pc_q;
        instr_code_d = instr_code_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        fault_d      = fault_q;
        unique case (state_q)
            ST_LOAD: begin
                if (load_fire) begin
                    load_ptr_d = load_ptr_q + ONE;
                end
                if (load_done) begin
                    prog_len_d = load_ptr_q + ONE;
                end
            end
            ST_RUN: begin
                // Jumps take priority over fetch; a legal jump flushes the held entry.
                if (jump_bad) begin
                    fault_d  = 1'b1;
                    halted_d = 1'b1;
                    valid_d  = 1'b0;
                end else if (JumpEn) begin
                    pc_d    = JumpTarget;
                    valid_d = 1'b0;
                end else if (out_free) begin
                    if (pc_q < prog_len_q) begin
                        instr_code_d = rd_data;
                        instr_pc_d   = pc_q;
                        valid_d      = 1'b1;
                        pc_d         = pc_q + ONE;
                    end else begin
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign LoadReady  = (state_q == ST_LOAD);
    assign InstrValid = valid_q;
    assign InstrCode  = instr_code_q;
    assign InstrPC    = instr_pc_q;
    assign Halted     = halted_q;
    assign Fault      = fault_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed cycle vectors, a full-store load sequence,
// and randomized programs checked against a transaction-level fetch model.
module tb_imem_fetch_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       LoadValid;
    logic [7:0] LoadData;
    logic       LoadLast;
    logic       LoadReady;
    logic       InstrReady;
    logic       InstrValid;
    logic [7:0] InstrCode;
    logic [7:0] InstrPC;
    logic       JumpEn;
    logic [7:0] JumpTarget;
    logic       Halted;
    logic       Fault;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    imem_fetch_sequencer #(
        .DEPTH  (36),
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .LoadValid  (LoadValid),
        .LoadData   (LoadData),
        .LoadLast   (LoadLast),
        .LoadReady  (LoadReady),
        .InstrReady (InstrReady),
        .InstrValid (InstrValid),
        .InstrCode  (InstrCode),
        .InstrPC    (InstrPC),
        .JumpEn     (JumpEn),
        .JumpTarget (JumpTarget),
        .Halted     (Halted),
        .Fault      (Fault)
    );

    typedef struct {
        logic       rst, lv;
        logic [7:0] ld;
        logic       ll, rdy, jmp;
        logic [7:0] tgt;
        logic       e_lr, e_v;
        logic [7:0] e_pc, e_code;
        logic       e_h, e_f;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic lv, logic [7:0] ld, logic ll, logic rdy,
                                logic jmp, logic [7:0] tgt, logic e_lr, logic e_v,
                                logic [7:0] e_pc, logic [7:0] e_code, logic e_h, logic e_f);
        vec_t v;
        v.rst = rst; v.lv = lv; v.ld = ld; v.ll = ll; v.rdy = rdy; v.jmp = jmp; v.tgt = tgt;
        v.e_lr = e_lr; v.e_v = e_v; v.e_pc = e_pc; v.e_code = e_code; v.e_h = e_h; v.e_f = e_f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic lv, input logic [7:0] ld, input logic ll,
                         input logic rdy, input logic jmp, input logic [7:0] tgt);
        Reset = rst; LoadValid = lv; LoadData = ld; LoadLast = ll;
        InstrReady = rdy; JumpEn = jmp; JumpTarget = tgt;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Vector rows: inputs before an edge, expected outputs after it (pc/code only when valid).
    task automatic build_table();
        // 1: basic 3-byte program, jump/ready ignored while loading, halt inputs ignored
        tbl.push_back(mk(1,0,8'h00,0,0,0,8'd0, 1,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,1,8'h11,0,1,1,8'd5, 1,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,1,8'h22,0,0,0,8'd0, 1,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,1,8'h33,1,1,0,8'd0, 0,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd0,8'h11,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd1,8'h22,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd2,8'h33,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,0,8'd0,8'h00,1,0));
        tbl.push_back(mk(0,1,8'h44,1,1,1,8'd0, 0,0,8'd0,8'h00,1,0));
        // 2: back-pressure holds (1,22) for three cycles
        tbl.push_back(mk(1,0,8'h00,0,0,0,8'd0, 1,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,1,8'h11,0,0,0,8'd0, 1,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,1,8'h22,0,0,0,8'd0, 1,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,1,8'h33,1,0,0,8'd0, 0,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,8'd0, 0,1,8'd0,8'h11,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd1,8'h22,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,8'd0, 0,1,8'd1,8'h22,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,8'd0, 0,1,8'd1,8'h22,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,8'd0, 0,1,8'd1,8'h22,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd2,8'h33,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,0,8'd0,8'h00,1,0));
        // 3: legal jump to 4 flushes the held (1,A1)
        tbl.push_back(mk(1,0,8'h00,0,0,0,8'd0, 1,0,8'd0,8'h00,0,0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0,1,8'hA0 + 8'(i),(i == 5),0,0,8'd0, (i != 5),0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,8'd0, 0,1,8'd0,8'hA0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd1,8'hA1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,8'd4, 0,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,8'd0, 0,1,8'd4,8'hA4,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd5,8'hA5,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,0,8'd0,8'h00,1,0));
        // 4: jump to ProgLen faults; fault is sticky
        tbl.push_back(mk(1,0,8'h00,0,0,0,8'd0, 1,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,1,8'hC0,0,0,0,8'd0, 1,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,1,8'hC1,0,0,0,8'd0, 1,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,1,8'hC2,1,0,0,8'd0, 0,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,8'd0, 0,1,8'd0,8'hC0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,8'd3, 0,0,8'd0,8'h00,1,1));
        tbl.push_back(mk(0,0,8'h00,0,1,1,8'd0, 0,0,8'd0,8'h00,1,1));
        tbl.push_back(mk(0,0,8'h00,0,0,0,8'd0, 0,0,8'd0,8'h00,1,1));
        // 6: reset mid-run, then a fresh 1-byte program
        tbl.push_back(mk(1,0,8'h00,0,0,0,8'd0, 1,0,8'd0,8'h00,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,1,8'hD0 + 8'(i),(i == 4),0,0,8'd0, (i != 4),0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd0,8'hD0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd1,8'hD1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd2,8'hD2,0,0));
        tbl.push_back(mk(1,0,8'h00,0,1,0,8'd0, 1,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,1,8'hAB,1,0,0,8'd0, 0,0,8'd0,8'h00,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,1,8'd0,8'hAB,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,0,8'd0, 0,0,8'd0,8'h00,1,0));
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].lv, tbl[i].ld, tbl[i].ll, tbl[i].rdy, tbl[i].jmp, tbl[i].tgt);
            step();
            chk($sformatf("vec%0d_loadready", i), 32'(LoadReady), 32'(tbl[i].e_lr));
            chk($sformatf("vec%0d_valid", i), 32'(InstrValid), 32'(tbl[i].e_v));
            chk($sformatf("vec%0d_halted", i), 32'(Halted), 32'(tbl[i].e_h));
            chk($sformatf("vec%0d_fault", i), 32'(Fault), 32'(tbl[i].e_f));
            if (tbl[i].e_v) begin
                chk($sformatf("vec%0d_pc", i), 32'(InstrPC), 32'(tbl[i].e_pc));
                chk($sformatf("vec%0d_code", i), 32'(InstrCode), 32'(tbl[i].e_code));
            end
        end
    endtask

    // 40 bytes offered without LoadLast: only the first 36 fit, then all 36 are fetched.
    task automatic full_store();
        logic [7:0] d;
        drive(1, 0, 8'h00, 0, 0, 0, 8'd0);
        step();
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("full_loadready%0d", i), 32'(LoadReady), 32'(i < 36));
            d = 8'(i) ^ 8'h5A;
            drive(0, 1, d, 0, 0, 0, 8'd0);
            step();
        end
        for (int k = 0; k < 36; k++) begin
            d = 8'(k) ^ 8'h5A;
            chk($sformatf("full_valid%0d", k), 32'(InstrValid), 32'd1);
            chk($sformatf("full_pc%0d", k), 32'(InstrPC), 32'(k));
            chk($sformatf("full_code%0d", k), 32'(InstrCode), 32'(d));
            drive(0, 0, 8'h00, 0, 1, 0, 8'd0);
            step();
        end
        chk("full_end_valid", 32'(InstrValid), 32'd0);
        chk("full_end_halted", 32'(Halted), 32'd1);
        chk("full_end_fault", 32'(Fault), 32'd0);
    endtask

    // Model: the program bytes plus the next PC decode expects to receive.
    task automatic rand_program(input int n);
        logic [7:0] prog [36];
        int         len, i, exp_next, guard;
        logic       lv, ll, rdy, jmp, bad, drain;
        logic [7:0] tgt, want;

        len = $urandom_range(1, 36);
        for (int k = 0; k < 36; k++) prog[k] = 8'($urandom);
        drive(1, 0, 8'h00, 0, 0, 0, 8'd0);
        step();
        i = 0;
        guard = 0;
        while (i < len && guard < 400) begin
            guard++;
            chk($sformatf("rnd%0d_loadready", n), 32'(LoadReady), 32'd1);
            lv = ($urandom_range(0, 3) != 0);
            ll = (i == len - 1) && ((len < 36) || ($urandom_range(0, 1) == 1));
            drive(0, lv, lv ? prog[i] : 8'($urandom), lv & ll, 1'($urandom),
                  1'($urandom), 8'($urandom));
            step();
            if (lv) i++;
        end
        chk($sformatf("rnd%0d_load_closed", n), 32'(LoadReady), 32'd0);

        exp_next = 0;
        bad = 1'b0;
        for (int cyc = 0; cyc < 400 && !Halted; cyc++) begin
            drain = (cyc > 150);
            rdy = drain ? 1'b1 : 1'($urandom);
            jmp = !drain && ($urandom_range(0, 11) == 0);
            tgt = 8'($urandom_range(0, len));
            if (InstrValid && rdy) begin
                want = (exp_next < 36) ? prog[exp_next] : 8'h00;
                chk($sformatf("rnd%0d_pc", n), 32'(InstrPC), 32'(exp_next));
                chk($sformatf("rnd%0d_code", n), 32'(InstrCode), 32'(want));
                exp_next++;
            end
            drive(0, 0, 8'h00, 0, rdy, jmp, tgt);
            step();
            if (jmp) begin
                if (int'(tgt) >= len) begin
                    chk($sformatf("rnd%0d_fault_valid", n), 32'(InstrValid), 32'd0);
                    chk($sformatf("rnd%0d_fault_halted", n), 32'(Halted), 32'd1);
                    chk($sformatf("rnd%0d_fault", n), 32'(Fault), 32'd1);
                    bad = 1'b1;
                    break;
                end
                exp_next = int'(tgt);
            end
        end
        if (!bad) begin
            chk($sformatf("rnd%0d_halted", n), 32'(Halted), 32'd1);
            chk($sformatf("rnd%0d_consumed", n), 32'(exp_next), 32'(len));
            chk($sformatf("rnd%0d_nofault", n), 32'(Fault), 32'd0);
            chk($sformatf("rnd%0d_end_valid", n), 32'(InstrValid), 32'd0);
        end
        drive(0, 0, 8'h00, 0, 0, 0, 8'd0);
    endtask

    initial begin
        drive(1, 0, 8'h00, 0, 0, 0, 8'd0);
        build_table();
        step();
        run_table();
        full_store();
        for (int n = 0; n < 10; n++) rand_program(n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
